int2fp_rr_scheduler: RTL and testbench

//  Shares one bit-serial unsigned-int -> IEEE-754 single-precision converter among N_REQ requesters.

---
 rtl/int2fp_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_int2fp_rr_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2fp_rr_scheduler.sv
// int2fp_rr_scheduler: N_REQ producers share one bit-serial uint32 -> fp32 converter.
// Define ROUND_NEAREST_EN for round-to-nearest-even packing (default truncates).
module int2fp_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                res_valid,
    output logic [31:0]         res_data,
    output logic [ID_W-1:0]     res_id,
    input  logic                res_ready,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   gnt_id;
    logic [31:0]       mant;
    logic [7:0]        expo;
    logic [31:0]       operand;
    logic [31:0]       packed_val;
    logic [N_REQ-1:0]  gnt;
    logic              gnt_any;
    logic              xfer;
    int                best;

    // Pick the valid requester closest to rr_ptr going upward.
    always_comb begin
        best    = N_REQ;
        gnt_id  = '0;
        operand = '0;
        gnt     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && ((i - int'(rr_ptr) + N_REQ) % N_REQ) < best) begin
                best   = (i - int'(rr_ptr) + N_REQ) % N_REQ;
                gnt_id = ID_W'(i);
            end
        end
        gnt_any = (best < N_REQ);
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                operand = req_data[32*i +: 32];
                gnt[i]  = gnt_any && (state == IDLE);
            end
        end
    end

    assign xfer      = gnt_any && (state == IDLE);
    assign req_ready = gnt & {N_REQ{rst_n}};
    assign busy      = (state != IDLE);

`ifdef ROUND_NEAREST_EN
    logic rnd_up;
    assign rnd_up = mant[7] & ((|mant[6:0]) | mant[8]);
`endif

    always_comb begin
        packed_val = '0;
        if (mant != '0) begin
`ifdef ROUND_NEAREST_EN
            packed_val = {1'b0, {expo, mant[30:8]} + 31'(rnd_up)};
`else
            packed_val = {1'b0, expo, mant[30:8]};
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xfer) state_nxt = (operand == '0) ? PACK : NORM;
            NORM: if (mant[31]) state_nxt = PACK;
            PACK: state_nxt = DONE;
            DONE: if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            mant      <= '0;
            expo      <= '0;
            id        <= '0;
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (xfer) begin
                    mant   <= operand;
                    expo   <= 8'd158;
                    id     <= gnt_id;
                    rr_ptr <= ID_W'((int'(gnt_id) + 1) % N_REQ);
                end
                NORM: if (!mant[31]) begin
                    mant <= mant << 1;
                    expo <= expo - 8'd1;
                end
                PACK: begin
                    res_data <= packed_val;
                    res_id   <= id;
                end
                DONE: begin
                    // First DONE cycle raises valid; handshake lowers it.
                    if (!res_valid) res_valid <= 1'b1;
                    else if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int2fp_rr_scheduler.sv
// tb_int2fp_rr_scheduler: transaction model + directed vectors for the shared
// int->fp converter; honours ROUND_NEAREST_EN like the design.
module tb_int2fp_rr_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [31:0]    res_data;
    logic [1:0]     res_id;
    logic           res_ready = 1'b1;
    logic           busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          got_i[$];
    logic [31:0] got_d[$];
    int          xid[$];
    int          xcyc[$];
    int          vq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int2fp_rr_scheduler #(.N_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference conversion straight from the IEEE-754 definition.
    function automatic logic [31:0] to_fp(input logic [31:0] x);
        int k;
        logic [31:0] n;
        logic [30:0] r;
        if (x == 0) return 32'h0;
        k = 0;
        for (int i = 0; i < 32; i++) if (x[i]) k = i;
        n = x << (31 - k);
        r = {8'(127 + k), n[30:8]};
`ifdef ROUND_NEAREST_EN
        if (n[7] && (n[6:0] != 0 || n[8])) r = r + 31'd1;
`endif
        return {1'b0, r};
    endfunction

    function automatic int lat(input logic [31:0] x);
        int k;
        if (x == 0) return 2;
        k = 0;
        for (int i = 0; i < 32; i++) if (x[i]) k = i;
        return (31 - k) + 3;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // Transaction-level model: idle/busy, countdown to valid, rr pointer.
    int          m_rr = 0;
    int          m_cnt = 0;
    int          m_id = 0;
    bit          m_busy = 0;
    bit          m_valid = 0;
    logic [31:0] m_data = '0;
    int          mg;
    logic [31:0] mx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr = 0; m_busy = 0; m_valid = 0; m_cnt = 0;
        end else if (!m_busy) begin
            mg = pick(req_valid, m_rr);
            if (mg >= 0) begin
                mx = req_data[32*mg +: 32];
                m_rr = (mg + 1) % N;
                m_busy = 1;
                m_cnt = lat(mx);
                m_data = to_fp(mx);
                m_id = mg;
            end
        end else if (m_valid) begin
            if (res_ready) begin
                m_valid = 0;
                m_busy = 0;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end
    end

    int         cg;
    logic [N-1:0] erdy;
    logic       pv = 1'b0;

    always @(negedge clk) begin
        cg = pick(req_valid, m_rr);
        erdy = '0;
        if (rst_n && !m_busy && cg >= 0) erdy[cg] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(erdy));
        check("busy", 32'(busy), 32'(m_busy));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid || !rst_n) begin
            check("res_data", res_data, rst_n ? m_data : 32'h0);
            check("res_id", 32'(res_id), rst_n ? 32'(m_id) : 32'h0);
        end
        if (rst_n && (req_valid & req_ready) != '0) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) xid.push_back(i);
            xcyc.push_back(cyc + 1);
        end
        if (res_valid && !pv) vq.push_back(cyc);
        pv = res_valid;
        if (res_valid && res_ready) begin
            got_d.push_back(res_data);
            got_i.push_back(int'(res_id));
        end
    end

    task automatic clear_logs();
        got_i.delete(); got_d.delete(); xid.delete(); xcyc.delete(); vq.delete();
    endtask

    task automatic push(input int i, input logic [31:0] x);
        bit ok;
        @(posedge clk); #1;
        req_data[32*i +: 32] = x;
        req_valid[i] = 1'b1;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin ok = 1; break; end
        end
        check("grant_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_results(input int n);
        bit ok;
        ok = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (got_d.size() >= n) begin ok = 1; break; end
        end
        check("result_wait", 32'(ok), 32'd1);
    endtask

    logic [31:0] t1_in [5]  = '{32'd10, 32'd25, 32'd100, 32'd0, 32'd255};
    logic [31:0] t1_exp [5] = '{32'h41200000, 32'h41C80000, 32'h42C80000,
                                32'h00000000, 32'h437F0000};
    int t3_exp [5] = '{0, 1, 2, 3, 0};
    bit ok;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // 1: single requester, literal results
        clear_logs();
        for (int j = 0; j < 5; j++) push(0, t1_in[j]);
        wait_results(5);
        for (int j = 0; j < 5 && j < got_d.size(); j++) begin
            check("t1_data", got_d[j], t1_exp[j]);
            check("t1_id", 32'(got_i[j]), 32'd0);
        end

        // 2: latency in edges from transfer to first valid
        clear_logs();
        push(1, 32'd10);
        wait_results(1);
        push(1, 32'd0);
        wait_results(2);
        if (vq.size() >= 2 && xcyc.size() >= 2) begin
            check("t2_lat_10", 32'(vq[0] - xcyc[0]), 32'd31);
            check("t2_lat_0", 32'(vq[1] - xcyc[1]), 32'd2);
        end else check("t2_logs", 32'(vq.size()), 32'd2);

        // 3: all requesters valid from reset, then rr pointer check
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(i + 1);
        req_valid = '1;
        #2;
        clear_logs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (xid.size() >= 5) begin ok = 1; break; end
        end
        check("t3_wait5", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        for (int j = 0; j < 5 && j < xid.size(); j++)
            check("t3_order", 32'(xid[j]), 32'(t3_exp[j]));
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (xid.size() >= 6) begin ok = 1; break; end
        end
        check("t3_wait6", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = '1;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (xid.size() >= 7) begin ok = 1; break; end
        end
        check("t3_wait7", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        if (xid.size() >= 7) begin
            check("t3_only2", 32'(xid[5]), 32'd2);
            check("t3_rr3", 32'(xid[6]), 32'd3);
        end
        wait_results(7);

        // 4: backpressure in DONE
        clear_logs();
        res_ready = 1'b0;
        push(3, 32'd100);
        req_data[31:0] = 32'd1;
        req_valid[0] = 1'b1;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; break; end
        end
        check("t4_valid_wait", 32'(ok), 32'd1);
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            check("t4_valid", 32'(res_valid), 32'd1);
            check("t4_data", res_data, 32'h42C80000);
            check("t4_id", 32'(res_id), 32'd3);
            check("t4_ready", 32'(req_ready), 32'd0);
            check("t4_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (req_ready[0]) begin ok = 1; break; end
        end
        check("t4_next_grant", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_results(2);

        // 5: rounding boundaries
        clear_logs();
        push(2, 32'h01000003);
        push(2, 32'hFFFFFFFF);
        wait_results(2);
        if (got_d.size() >= 2) begin
`ifdef ROUND_NEAREST_EN
            check("t5_rne_a", got_d[0], 32'h4B800002);
            check("t5_rne_b", got_d[1], 32'h4F800000);
`else
            check("t5_trunc_a", got_d[0], 32'h4B800001);
            check("t5_trunc_b", got_d[1], 32'h4F7FFFFF);
`endif
        end

        // 6: reset mid-NORM
        push(1, 32'd1);
        req_data[31:0] = 32'd10;
        req_valid = '1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ready", 32'(req_ready), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_data", res_data, 32'd0);
        check("t6_id", 32'(res_id), 32'd0);
        clear_logs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (xid.size() >= 1) begin ok = 1; break; end
        end
        check("t6_grant_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        if (xid.size() >= 1) check("t6_first_grant", 32'(xid[0]), 32'd0);
        wait_results(1);
        if (got_d.size() >= 1) begin
            check("t6_res_id", 32'(got_i[0]), 32'd0);
            check("t6_res_data", got_d[0], 32'h41200000);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
